// File: rtl/board_test_sequencer.sv
// Exhaustive-sweep board tester: drives every input pattern, waits a settle time,
// compares masked board outputs against a golden lookup and tallies mismatches.
module board_test_sequencer #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned N_OUT  = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [N_IN-1:0]   stim,
  input  logic [N_OUT-1:0]  resp,
  output logic [N_IN-1:0]   exp_addr,
  input  logic [N_OUT-1:0]  exp_data,
  input  logic [N_OUT-1:0]  cmp_mask,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [N_IN-1:0]   first_fail,
  output logic              first_fail_valid
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned ERR_W = 8;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  LAST_PAT    = {N_IN{1'b1}};
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  settle_cnt;
  logic              mismatch;
  logic [ERR_W-1:0]  err_next;

  // Golden table is addressed directly by the applied pattern.
  assign exp_addr = stim;

  // Masked compare and saturating error count for the current SAMPLE cycle.
  always_comb begin
    mismatch = |((resp ^ exp_data) & cmp_mask);
    err_next = err_count;
    if (mismatch && (err_count != ERR_MAX)) begin
      err_next = err_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      stim             <= '0;
      settle_cnt       <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
    end else if (abort) begin
      // Results are kept so a debugger can inspect the aborted sweep.
      state      <= S_IDLE;
      stim       <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state            <= S_SETTLE;
            stim             <= '0;
            settle_cnt       <= SETTLE_LOAD;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        S_SAMPLE: begin
          err_count <= err_next;
          if (mismatch && !first_fail_valid) begin
            first_fail       <= stim;
            first_fail_valid <= 1'b1;
          end
          if (stim == LAST_PAT) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            state      <= S_SETTLE;
            stim       <= stim + 1'b1;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
